eth_tx_frame_arb: RTL and testbench

- Frame-granular arbiter that shares the single 8-bit TX AXI-Stream input of the 1G MAC between S_COUNT requesters.
- Grants one whole frame at a time, round-robin with optional strict priority for port 0.
- Enforces a maximum frame length by truncating and marking oversize frames.
- Sits between the per-source TX FIFOs and the MAC tx_axis port, in the MAC tx_clk domain.

---
 rtl/eth_tx_frame_arb_pkg.sv | 37 +++
 rtl/eth_axis_skid_reg.sv | 68 ++++++
 rtl/eth_tx_frame_arb.sv | 150 +++++++++++++++
 tb/tb_eth_tx_frame_arb.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_frame_arb_pkg.sv
// Shared types and helpers for the MAC TX frame arbiter.
package eth_tx_frame_arb_pkg;

  typedef enum logic [1:0] {StIdle, StFwd, StDrain} state_e;

  localparam int unsigned MaxPorts = 8;
  localparam int unsigned SelW     = 3;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Doubling the request vector turns the wrap-around scan into a plain window search.
  function automatic logic [SelW-1:0] rr_select(input logic [MaxPorts-1:0] req,
                                                input int unsigned       n,
                                                input logic [SelW-1:0]   last);
    logic [2*MaxPorts-1:0] dbl;
    logic [SelW-1:0]       pick;
    logic                  found;
    int unsigned           lo;
    dbl   = '0;
    pick  = '0;
    found = 1'b0;
    lo    = int'(last) + 1;
    for (int unsigned i = 0; i < 2 * MaxPorts; i++) begin
      if (i < 2 * n) dbl[i] = req[i % n];
    end
    for (int unsigned i = 0; i < 2 * MaxPorts; i++) begin
      if (!found && dbl[i] && i >= lo && i < lo + n) begin
        pick  = SelW'(i % n);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/eth_axis_skid_reg.sv
// Registered 8-bit AXI-Stream stage (data, last, user) with a 2-entry skid and registered ready.
module eth_axis_skid_reg (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  input  logic       s_last_i,
  input  logic       s_user_i,
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  input  logic       m_ready_i,
  output logic       m_last_o,
  output logic       m_user_o
);

  logic [9:0] out_q, out_d, skid_q, skid_d;
  logic       out_valid_q, out_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       ready_q, ready_d;
  logic       accept;

  always_comb begin
    accept       = s_valid_i && ready_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || m_ready_i) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = {s_user_i, s_last_i, s_data_i};
      end
    end else if (accept) begin
      skid_d       = {s_user_i, s_last_i, s_data_i};
      skid_valid_d = 1'b1;
    end
    // Ready only looks at our own next state, never at m_ready_i directly.
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign s_ready_o = ready_q;
  assign m_data_o  = out_q[7:0];
  assign m_last_o  = out_q[8];
  assign m_user_o  = out_q[9];
  assign m_valid_o = out_valid_q;

endmodule

// File: rtl/eth_tx_frame_arb.sv
// Frame-granular round-robin arbiter feeding the 1G MAC TX stream, with length truncation.
module eth_tx_frame_arb
  import eth_tx_frame_arb_pkg::*;
#(
  parameter int unsigned S_COUNT       = 4,
  parameter int unsigned MAX_FRAME_LEN = 1522,
  parameter int unsigned HIGH_PRIO_EN  = 0,
  localparam int unsigned IdxW         = idx_width(S_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [S_COUNT*8-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]   s_axis_tvalid,
  output logic [S_COUNT-1:0]   s_axis_tready,
  input  logic [S_COUNT-1:0]   s_axis_tlast,
  input  logic [S_COUNT-1:0]   s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic                 enable,
  output logic                 grant_valid,
  output logic [IdxW-1:0]      grant_index,
  output logic                 trunc_pulse
);

  localparam int unsigned          LenW      = $clog2(MAX_FRAME_LEN + 1);
  localparam logic [LenW-1:0]      LenLast   = LenW'(MAX_FRAME_LEN - 1);
  localparam logic [MaxPorts-1:0]  Port0Mask = MaxPorts'(1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d, last_q, last_d;
  logic            grant_valid_q, grant_valid_d;
  logic [LenW-1:0] len_q, len_d;
  logic            trunc_q, trunc_d;

  logic [MaxPorts-1:0] req;
  logic [IdxW-1:0]     winner;
  logic [7:0]          g_data;
  logic                g_valid, g_last, g_user, at_limit;
  logic                sk_in_valid, sk_in_ready, sk_in_last, sk_in_user;

  always_comb begin
    req                = '0;
    req[S_COUNT-1:0]   = s_axis_tvalid;
    if (HIGH_PRIO_EN != 0 && req[0]) begin
      winner = '0;
    end else if (HIGH_PRIO_EN != 0) begin
      winner = IdxW'(rr_select(req & ~Port0Mask, S_COUNT, SelW'(last_q)));
    end else begin
      winner = IdxW'(rr_select(req, S_COUNT, SelW'(last_q)));
    end
  end

  assign g_data  = s_axis_tdata[{grant_q, 3'b000} +: 8];
  assign g_valid = s_axis_tvalid[grant_q];
  assign g_last  = s_axis_tlast[grant_q];
  assign g_user  = s_axis_tuser[grant_q];

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    grant_valid_d = grant_valid_q;
    len_d         = len_q;
    trunc_d       = 1'b0;
    s_axis_tready = '0;
    sk_in_valid   = 1'b0;
    // The beat that reaches the limit without tlast becomes a forced, flagged end of frame.
    at_limit      = (len_q == LenLast) && !g_last;
    sk_in_last    = g_last | at_limit;
    sk_in_user    = g_user | at_limit;
    unique case (state_q)
      StIdle: begin
        if (enable && |s_axis_tvalid) begin
          grant_d       = winner;
          grant_valid_d = 1'b1;
          len_d         = '0;
          state_d       = StFwd;
        end
      end
      StFwd: begin
        s_axis_tready[grant_q] = sk_in_ready;
        sk_in_valid            = g_valid;
        if (g_valid && sk_in_ready) begin
          if (g_last) begin
            last_d        = grant_q;
            len_d         = '0;
            grant_valid_d = 1'b0;
            state_d       = StIdle;
          end else if (at_limit) begin
            len_d   = '0;
            trunc_d = 1'b1;
            state_d = StDrain;
          end else begin
            len_d = len_q + 1'b1;
          end
        end
      end
      StDrain: begin
        s_axis_tready[grant_q] = 1'b1;
        if (g_valid && g_last) begin
          last_d        = grant_q;
          grant_valid_d = 1'b0;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      last_q        <= IdxW'(S_COUNT - 1);
      grant_valid_q <= 1'b0;
      len_q         <= '0;
      trunc_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      grant_valid_q <= grant_valid_d;
      len_q         <= len_d;
      trunc_q       <= trunc_d;
    end
  end

  eth_axis_skid_reg u_skid (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .s_data_i  (g_data),
    .s_valid_i (sk_in_valid),
    .s_ready_o (sk_in_ready),
    .s_last_i  (sk_in_last),
    .s_user_i  (sk_in_user),
    .m_data_o  (m_axis_tdata),
    .m_valid_o (m_axis_tvalid),
    .m_ready_i (m_axis_tready),
    .m_last_o  (m_axis_tlast),
    .m_user_o  (m_axis_tuser)
  );

  assign grant_valid = grant_valid_q;
  assign grant_index = grant_q;
  assign trunc_pulse = trunc_q;

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// Directed bench: dut_a is the default build, dut_b has port-0 priority and a 4-beat limit.
module tb_eth_tx_frame_arb;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, enable, m_tready;
  logic [N*8-1:0] s_tdata;
  logic [N-1:0]   s_tvalid, s_tlast, s_tuser;

  logic [N-1:0] a_tready, b_tready;
  logic [7:0]   a_mdata, b_mdata;
  logic         a_mv, a_ml, a_mu, a_gv, a_tp, b_mv, b_ml, b_mu, b_gv, b_tp;
  logic [1:0]   a_gi, b_gi;

  eth_tx_frame_arb #(.S_COUNT(4), .MAX_FRAME_LEN(1522), .HIGH_PRIO_EN(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(a_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mv), .m_axis_tready(m_tready),
    .m_axis_tlast(a_ml), .m_axis_tuser(a_mu), .enable(enable), .grant_valid(a_gv),
    .grant_index(a_gi), .trunc_pulse(a_tp)
  );

  eth_tx_frame_arb #(.S_COUNT(4), .MAX_FRAME_LEN(4), .HIGH_PRIO_EN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(b_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mv), .m_axis_tready(m_tready),
    .m_axis_tlast(b_ml), .m_axis_tuser(b_mu), .enable(enable), .grant_valid(b_gv),
    .grant_index(b_gi), .trunc_pulse(b_tp)
  );

  bit sel;
  logic [N-1:0] x_tready;
  logic [7:0]   x_mdata;
  logic         x_mv, x_ml, x_mu, x_gv, x_tp;
  logic [1:0]   x_gi;
  assign x_tready = sel ? b_tready : a_tready;
  assign x_mdata  = sel ? b_mdata : a_mdata;
  assign x_mv     = sel ? b_mv : a_mv;
  assign x_ml     = sel ? b_ml : a_ml;
  assign x_mu     = sel ? b_mu : a_mu;
  assign x_gv     = sel ? b_gv : a_gv;
  assign x_gi     = sel ? b_gi : a_gi;
  assign x_tp     = sel ? b_tp : a_tp;

  int         cyc, n_chk, n_pass;
  int         src_left[N], src_len[N], src_beat[N];
  logic       src_user[N];
  int         gnt_q[$];
  logic [9:0] out_q[$], exp_q[$];
  int         trunc_cnt, stab_err, first_mv;
  int         nfire[N], first_acc[N], last_acc[N];
  bit         rand_rdy;
  logic       prev_stall, prev_gv;
  logic [9:0] prev_beat;

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      s_tvalid[p]        = (src_left[p] > 0);
      s_tdata[p*8 +: 8]  = {2'(p), 6'(src_beat[p])};
      s_tlast[p]         = (src_beat[p] == src_len[p] - 1);
      s_tuser[p]         = src_user[p];
    end
  endtask

  task automatic clear_src();
    for (int p = 0; p < N; p++) begin
      src_left[p] = 0; src_len[p] = 1; src_beat[p] = 0; src_user[p] = 1'b0;
    end
    drive();
  endtask

  task automatic clear_mon();
    gnt_q.delete(); out_q.delete(); exp_q.delete();
    trunc_cnt = 0; stab_err = 0; first_mv = -1;
    prev_stall = 1'b0; prev_gv = 1'b0;
    for (int p = 0; p < N; p++) begin
      nfire[p] = 0; first_acc[p] = -1; last_acc[p] = -1;
    end
  endtask

  // One clock: sample everything at the falling edge, advance the sources after the rising edge.
  task automatic step();
    logic [N-1:0] fire;
    @(negedge clk);
    cyc++;
    fire = s_tvalid & x_tready;
    if (prev_stall && (x_mv !== 1'b1 || {x_mu, x_ml, x_mdata} !== prev_beat)) stab_err++;
    prev_stall = x_mv && !m_tready;
    prev_beat  = {x_mu, x_ml, x_mdata};
    if (x_mv && m_tready) out_q.push_back({x_mu, x_ml, x_mdata});
    if (x_mv && first_mv < 0) first_mv = cyc;
    if (x_gv && !prev_gv) gnt_q.push_back(int'(x_gi));
    prev_gv = x_gv;
    if (x_tp) trunc_cnt++;
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (fire[p]) begin
        nfire[p]++;
        if (first_acc[p] < 0) first_acc[p] = cyc;
        last_acc[p] = cyc;
        if (src_beat[p] == src_len[p] - 1) begin
          src_beat[p] = 0;
          src_left[p]--;
        end else begin
          src_beat[p]++;
        end
      end
    end
    if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
    drive();
  endtask

  task automatic do_reset(input bit use_b);
    sel = use_b; rand_rdy = 1'b0; m_tready = 1'b1; enable = 1'b1;
    rst_n = 1'b0;
    clear_src();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) step();
    clear_mon();
  endtask

  function automatic bit busy();
    bit b = x_gv || x_mv;
    for (int p = 0; p < N; p++) if (src_left[p] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic run_done(input int limit);
    int n = 0;
    while (n < limit && busy()) begin
      step();
      n++;
    end
    n_chk++;
    if (busy()) $display("FAIL run_timeout still busy after %0d cycles, required idle", n);
    else n_pass++;
  endtask

  // Beats follow the source pattern {port, beat index}; a cut frame ends early with user set.
  task automatic push_frame(input int p, input int len, input int max_len, input logic user);
    int   nb = (len > max_len) ? max_len : len;
    logic lastb;
    for (int b = 0; b < nb; b++) begin
      lastb = (b == nb - 1);
      exp_q.push_back({user | (lastb & (len > max_len)), lastb, 2'(p), 6'(b)});
    end
  endtask

  function automatic int stream_diffs();
    int d = 0;
    if (out_q.size() != exp_q.size()) d++;
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) if (out_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  function automatic int gnt_code();
    int g = 0;
    foreach (gnt_q[i]) g = g * 10 + gnt_q[i] + 1;
    return g;
  endfunction

  task automatic test_reset();
    sel = 1'b0; m_tready = 1'b1; enable = 1'b1; rst_n = 1'b0;
    clear_src();
    @(posedge clk);
    #1;
    n_chk++; if (a_mv !== 1'b0) $display("FAIL reset_mvalid got %b want 0", a_mv); else n_pass++;
    n_chk++; if (a_gv !== 1'b0) $display("FAIL reset_gvalid got %b want 0", a_gv); else n_pass++;
    n_chk++; if (a_tready !== 4'h0) $display("FAIL reset_tready got %h want 0", a_tready);
    else n_pass++;
    n_chk++; if ({a_tp, a_ml, a_mu, a_mdata} !== 11'h0)
      $display("FAIL reset_outs got %h want 0", {a_tp, a_ml, a_mu, a_mdata}); else n_pass++;
    n_chk++; if ({b_mv, b_gv, b_gi} !== 4'h0)
      $display("FAIL reset_b got %h want 0", {b_mv, b_gv, b_gi}); else n_pass++;
    rst_n = 1'b1;
    repeat (3) step();
    n_chk++; if ({a_gv, a_tready} !== 5'h0)
      $display("FAIL idle_no_req got %h want 0", {a_gv, a_tready}); else n_pass++;
  endtask

  task automatic test_two_ports();
    int req;
    do_reset(1'b0);
    src_len[0] = 3; src_left[0] = 1; src_len[2] = 3; src_left[2] = 1;
    drive();
    req = cyc + 1;
    run_done(40);
    push_frame(0, 3, 1522, 1'b0);
    push_frame(2, 3, 1522, 1'b0);
    n_chk++; if (gnt_code() != 13) $display("FAIL two_grants got %0d want 13", gnt_code());
    else n_pass++;
    n_chk++; if (first_acc[0] - req != 1)
      $display("FAIL first_accept got %0d want 1", first_acc[0] - req); else n_pass++;
    n_chk++; if (first_mv - req != 2)
      $display("FAIL first_mvalid got %0d want 2", first_mv - req); else n_pass++;
    n_chk++; if (first_acc[2] - last_acc[0] != 2)
      $display("FAIL input_gap got %0d want 2", first_acc[2] - last_acc[0]); else n_pass++;
    n_chk++; if (stream_diffs() != 0)
      $display("FAIL two_stream got %0d diffs want 0", stream_diffs()); else n_pass++;
  endtask

  task automatic test_rotation();
    do_reset(1'b0);
    for (int p = 0; p < N; p++) begin
      src_len[p] = p + 1; src_left[p] = 2;
    end
    drive();
    run_done(200);
    for (int r = 0; r < 2; r++) for (int p = 0; p < N; p++) push_frame(p, p + 1, 1522, 1'b0);
    n_chk++; if (gnt_code() != 12341234)
      $display("FAIL rotation got %0d want 12341234", gnt_code()); else n_pass++;
    n_chk++; if (stream_diffs() != 0)
      $display("FAIL rotation_stream got %0d diffs want 0", stream_diffs()); else n_pass++;
  endtask

  task automatic test_high_prio();
    do_reset(1'b1);
    src_len[0] = 2; src_left[0] = 3; src_len[1] = 2; src_left[1] = 1;
    drive();
    run_done(60);
    for (int f = 0; f < 3; f++) push_frame(0, 2, 4, 1'b0);
    push_frame(1, 2, 4, 1'b0);
    n_chk++; if (gnt_code() != 1112) $display("FAIL prio_grants got %0d want 1112", gnt_code());
    else n_pass++;
    n_chk++; if (stream_diffs() != 0)
      $display("FAIL prio_stream got %0d diffs want 0", stream_diffs()); else n_pass++;
  endtask

  task automatic test_trunc();
    do_reset(1'b1);
    src_len[1] = 7; src_left[1] = 1;
    src_len[2] = 3; src_left[2] = 1;
    src_len[3] = 4; src_left[3] = 1;
    drive();
    run_done(60);
    push_frame(1, 7, 4, 1'b0);
    push_frame(2, 3, 4, 1'b0);
    push_frame(3, 4, 4, 1'b0);
    n_chk++; if (gnt_code() != 234) $display("FAIL trunc_grants got %0d want 234", gnt_code());
    else n_pass++;
    n_chk++; if (trunc_cnt != 1) $display("FAIL trunc_pulses got %0d want 1", trunc_cnt);
    else n_pass++;
    n_chk++; if (nfire[1] != 7) $display("FAIL trunc_consumed got %0d want 7", nfire[1]);
    else n_pass++;
    n_chk++; if (stream_diffs() != 0)
      $display("FAIL trunc_stream got %0d diffs want 0", stream_diffs()); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    rand_rdy = 1'b1;
    src_len[3] = 64; src_left[3] = 1; src_user[3] = 1'b1;
    drive();
    run_done(600);
    rand_rdy = 1'b0; m_tready = 1'b1;
    push_frame(3, 64, 1522, 1'b1);
    n_chk++; if (stream_diffs() != 0)
      $display("FAIL stall_stream got %0d diffs want 0", stream_diffs()); else n_pass++;
    n_chk++; if (stab_err != 0) $display("FAIL stall_stable got %0d changes want 0", stab_err);
    else n_pass++;
    n_chk++; if (nfire[3] != 64) $display("FAIL stall_accepted got %0d want 64", nfire[3]);
    else n_pass++;
  endtask

  task automatic test_enable_reset();
    int n = 0;
    do_reset(1'b0);
    src_len[1] = 6; src_left[1] = 2; src_len[2] = 8; src_left[2] = 1;
    drive();
    repeat (3) step();
    enable = 1'b0;
    repeat (25) step();
    push_frame(1, 6, 1522, 1'b0);
    n_chk++; if (gnt_code() != 2) $display("FAIL en_grants got %0d want 2", gnt_code());
    else n_pass++;
    n_chk++; if (stream_diffs() != 0)
      $display("FAIL en_stream got %0d diffs want 0", stream_diffs()); else n_pass++;
    n_chk++; if ({a_gv, nfire[2] != 0} !== 2'b00)
      $display("FAIL en_no_grant got gv=%b p2beats=%0d want 0,0", a_gv, nfire[2]); else n_pass++;
    enable = 1'b1;
    while (n < 5 && !a_gv) begin
      step();
      n++;
    end
    n_chk++; if ({a_gv, a_gi} !== 3'b110)
      $display("FAIL en_resume got gv=%b gi=%0d want 1,2", a_gv, a_gi); else n_pass++;
    repeat (2) step();
    n_chk++; if (a_mv !== 1'b1) $display("FAIL pre_reset_mvalid got %b want 1", a_mv);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({a_mv, a_gv, a_tready} !== 6'h0)
      $display("FAIL async_reset got %h want 0", {a_mv, a_gv, a_tready}); else n_pass++;
    clear_src();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) step();
    clear_mon();
    src_len[0] = 2; src_left[0] = 1; src_len[3] = 2; src_left[3] = 1;
    drive();
    run_done(40);
    push_frame(0, 2, 1522, 1'b0);
    push_frame(3, 2, 1522, 1'b0);
    n_chk++; if (gnt_code() != 14) $display("FAIL post_reset_grants got %0d want 14", gnt_code());
    else n_pass++;
    n_chk++; if (stream_diffs() != 0)
      $display("FAIL post_reset_stream got %0d diffs want 0", stream_diffs()); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; cyc = 0; n_chk = 0; n_pass = 0;
    sel = 1'b0; rand_rdy = 1'b0; m_tready = 1'b1; enable = 1'b1;
    clear_src();
    clear_mon();
    test_reset();
    test_two_ports();
    test_rotation();
    test_high_prio();
    test_trunc();
    test_stall();
    test_enable_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d, required completion", cyc);
    $fatal(1);
  end

endmodule
